// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the unified-memory port arbiter.
package pipe_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [DATA_W_DEFAULT/8-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Per-transaction wait-cycle counter; flags when TIMEOUT wait cycles have elapsed.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between fetch and MEM stages,
// with registered completion pulses, pipeline stalls and a transaction watchdog.
module mem_port_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_valid,
  output logic                stall_fetch,
  output logic                stall_mem,
  output logic                bus_err
);

  arb_state_t state_q, state_d;

  logic                m_req_q, m_we_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [DATA_W/8-1:0] m_be_q;
  logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;
  logic                if_valid_q, mem_valid_q, bus_err_q;

  logic busy, grant_mem, grant_if, done, abort, expired;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_mem | grant_if),
    .enable  (busy & ~m_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = DATA;
        end else if (grant_if) begin
          state_d = FETCH;
        end
      end
      FETCH, DATA: begin
        if (done || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The !valid terms stop a requester re-issuing while its completion pulse is visible.
  always_comb begin
    busy        = (state_q != IDLE);
    grant_mem   = (state_q == IDLE) && mem_req && !mem_valid_q;
    grant_if    = (state_q == IDLE) && !grant_mem && if_req && !if_valid_q;
    done        = busy && m_ready;
    abort       = busy && !m_ready && expired;
    stall_mem   = mem_req && !mem_valid_q;
    stall_fetch = (if_req && !if_valid_q) || stall_mem;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if (grant_mem) begin
        m_req_q   <= 1'b1;
        m_we_q    <= mem_we;
        m_addr_q  <= mem_addr;
        m_wdata_q <= mem_wdata;
        m_be_q    <= mem_be;
      end else if (grant_if) begin
        m_req_q  <= 1'b1;
        m_we_q   <= 1'b0;
        m_addr_q <= if_addr;
        m_be_q   <= '1;
      end
      if (done) begin
        m_req_q <= 1'b0;
        m_we_q  <= 1'b0;
        if (state_q == FETCH) begin
          if_rdata_q <= m_rdata;
          if_valid_q <= 1'b1;
        end else begin
          mem_valid_q <= 1'b1;
          if (!m_we_q) begin
            mem_rdata_q <= m_rdata;
          end
        end
      end else if (abort) begin
        m_req_q   <= 1'b0;
        m_we_q    <= 1'b0;
        bus_err_q <= 1'b1;
        if (state_q == FETCH) begin
          if_rdata_q <= '0;
          if_valid_q <= 1'b1;
        end else begin
          mem_rdata_q <= '0;
          mem_valid_q <= 1'b1;
        end
      end
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_valid = mem_valid_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on negedges.
module tb_mem_port_arbiter;
  import pipe_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_req, mem_req, mem_we, m_ready;
  logic [ADDR_W-1:0]   if_addr, mem_addr;
  logic [DATA_W-1:0]   mem_wdata, m_rdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                m_req, m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0]   if_rdata, mem_rdata;
  logic                if_valid, mem_valid, stall_fetch, stall_mem, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_be        (m_be),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem),
    .bus_err     (bus_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; m_ready = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_be = '0; m_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_m_req", m_req, 0);
    check_eq("rst_m_we", m_we, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_m_wdata", m_wdata, 0);
    check_eq("rst_m_be", m_be, 0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_mem_rdata", mem_rdata, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_stalls", {stall_fetch, stall_mem}, 0);
    check_eq("rst_state", dut.state_q, IDLE);

    // Single fetch, ready in first bus cycle
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(negedge clk);
    check_eq("f_m_req", m_req, 1);
    check_eq("f_m_addr", m_addr, 32'h40);
    check_eq("f_m_we", m_we, 0);
    check_eq("f_m_be", m_be, BE_ALL);
    check_eq("f_stall", stall_fetch, 1);
    check_eq("f_valid_early", if_valid, 0);
    m_ready = 1'b1; m_rdata = 32'h0050_0093;
    @(negedge clk);
    check_eq("f_valid", if_valid, 1);
    check_eq("f_rdata", if_rdata, 32'h0050_0093);
    check_eq("f_m_req_drop", m_req, 0);
    check_eq("f_stall_release", stall_fetch, 0);
    m_ready = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check_eq("f_valid_once", if_valid, 0);
    check_eq("f_idle_m_req", m_req, 0);

    // Simultaneous requests: MEM load first, then the waiting fetch
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000; mem_be = 4'hF;
    @(negedge clk);
    check_eq("s_m_addr_mem", m_addr, 32'h1000);
    check_eq("s_m_req", m_req, 1);
    check_eq("s_stalls", {stall_fetch, stall_mem}, 2'b11);
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("s_mem_valid", mem_valid, 1);
    check_eq("s_mem_rdata", mem_rdata, 32'h1234_5678);
    check_eq("s_if_valid", if_valid, 0);
    check_eq("s_stalls_mid", {stall_fetch, stall_mem}, 2'b10);
    m_ready = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check_eq("s_fetch_req", m_req, 1);
    check_eq("s_fetch_addr", m_addr, 32'h44);
    check_eq("s_mem_valid_once", mem_valid, 0);
    m_ready = 1'b1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    check_eq("s_if_valid2", if_valid, 1);
    check_eq("s_if_rdata", if_rdata, 32'h13);
    m_ready = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // Store with four wait cycles; bus fields must hold and mem_rdata must not change
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
    mem_be = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("st_bus", {m_req, m_we, m_be, m_addr, m_wdata},
               {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF});
      check_eq("st_hold", {mem_valid, stall_mem}, 2'b01);
      if (i == 4) begin
        m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
      end
    end
    @(negedge clk);
    check_eq("st_valid", mem_valid, 1);
    check_eq("st_rdata_kept", mem_rdata, 32'h1234_5678);
    check_eq("st_bus_drop", {m_req, m_we}, 2'b00);
    m_ready = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check_eq("st_valid_once", mem_valid, 0);

    // Ready arrives in the very cycle the watchdog expires: completion wins
    mem_req = 1'b1; mem_addr = 32'h4000; mem_be = 4'hF;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check_eq("rt_wait_req", m_req, 1);
      if (i == 9) begin
        m_ready = 1'b1; m_rdata = 32'hCAFE_0001;
      end
    end
    @(negedge clk);
    check_eq("rt_valid", mem_valid, 1);
    check_eq("rt_rdata", mem_rdata, 32'hCAFE_0001);
    check_eq("rt_no_err", bus_err, 0);
    m_ready = 1'b0; mem_req = 1'b0;
    @(negedge clk);

    // Hung load: abort after TIMEOUT wait cycles
    mem_req = 1'b1; mem_addr = 32'h3000;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check_eq("to_wait", {m_req, bus_err}, 2'b10);
    end
    @(negedge clk);
    check_eq("to_m_req", m_req, 0);
    check_eq("to_valid", mem_valid, 1);
    check_eq("to_rdata", mem_rdata, 0);
    check_eq("to_bus_err", bus_err, 1);
    check_eq("to_state", dut.state_q, IDLE);
    mem_req = 1'b0;
    @(negedge clk);
    check_eq("to_valid_once", mem_valid, 0);
    check_eq("to_err_sticky", bus_err, 1);
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    check_eq("to_next_req", {m_req, m_addr}, {1'b1, 32'h80});
    m_ready = 1'b1; m_rdata = 32'h0000_ABCD;
    @(negedge clk);
    check_eq("to_next_valid", if_valid, 1);
    check_eq("to_next_rdata", if_rdata, 32'hABCD);
    check_eq("to_err_still", bus_err, 1);
    m_ready = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // Reset in DATA abandons the transaction even with m_ready present
    mem_req = 1'b1; mem_addr = 32'h5000;
    @(negedge clk);
    check_eq("rd_state", dut.state_q, DATA);
    check_eq("rd_m_req", m_req, 1);
    reset = 1'b0; mem_req = 1'b0; m_ready = 1'b1; m_rdata = 32'h55;
    @(negedge clk);
    check_eq("rd_m_req_clr", m_req, 0);
    check_eq("rd_no_valid", mem_valid, 0);
    check_eq("rd_err_clr", bus_err, 0);
    check_eq("rd_rdata_clr", mem_rdata, 0);
    check_eq("rd_state_idle", dut.state_q, IDLE);
    reset = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_after", {mem_valid, m_req}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
